ifstage_prefetch: RTL

//  Instruction-fetch front end feeding DECSTAGE. Holds the fetch PC, issues word reads to

---
 rtl/ifstage_prefetch_pkg.sv | 18 +
 rtl/ifstage_prefetch_if.sv | 26 ++
 rtl/ifstage_prefetch_queue.sv | 96 +++++++++
 rtl/ifstage_prefetch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/ifstage_prefetch_pkg.sv
// Shared definitions for the instruction-fetch front end: FSM state encodings,
// PC arithmetic constants and the word-alignment helper.
package ifstage_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t S_IDLE = 2'd0;
    localparam fetch_state_t S_WAIT = 2'd1;
    localparam fetch_state_t S_DROP = 2'd2;

    localparam logic [31:0] PC_INCR          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/ifstage_prefetch_if.sv
// Bundle of the fetch unit's memory, redirect and decode-side signals.
// The fetch unit uses the master view; memory/execute/decode use the slave view.
interface ifstage_prefetch_if;

    logic        Br_valid;
    logic [31:0] Br_target;
    logic        IMem_req;
    logic [31:0] IMem_addr;
    logic        IMem_ack;
    logic [31:0] IMem_rdata;
    logic [31:0] Instr;
    logic [31:0] Instr_PC;
    logic        Instr_valid;
    logic        Instr_ready;

    modport master (
        input  Br_valid, Br_target, IMem_ack, IMem_rdata, Instr_ready,
        output IMem_req, IMem_addr, Instr, Instr_PC, Instr_valid
    );

    modport slave (
        output Br_valid, Br_target, IMem_ack, IMem_rdata, Instr_ready,
        input  IMem_req, IMem_addr, Instr, Instr_PC, Instr_valid
    );

endinterface

// File: rtl/ifstage_prefetch_queue.sv
// Small FIFO of {PC, instruction} pairs with flush. The head and valid flag are
// registered: they are computed from next-cycle pointer state, so outputs never glitch.
module ifstage_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r, rd_ptr_r, wr_ptr_s, rd_ptr_s;
    logic [CW-1:0]    count_r, count_s;
    logic             push_eff_s, pop_eff_s;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] head_r;
    logic             valid_r;

    // Qualify push/pop: flush wins, pop needs data, push needs a free slot (or a pop).
    always_comb begin
        pop_eff_s  = pop && (count_r != {CW{1'b0}}) && !flush;
        push_eff_s = push && !flush && ((count_r < DEPTH_C) || pop_eff_s);
    end

    // Next pointer/count state.
    always_comb begin
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        count_s  = count_r;
        if (flush) begin
            wr_ptr_s = {PW{1'b0}};
            rd_ptr_s = {PW{1'b0}};
            count_s  = {CW{1'b0}};
        end else begin
            wr_ptr_s = push_eff_s ? (wr_ptr_r + PW'(1'b1)) : wr_ptr_r;
            rd_ptr_s = pop_eff_s  ? (rd_ptr_r + PW'(1'b1)) : rd_ptr_r;
            count_s  = count_r + CW'(push_eff_s) - CW'(pop_eff_s);
        end
    end

    // Head seen next cycle; a push landing on the new read slot bypasses the array.
    always_comb begin
        head_s = {WIDTH{1'b0}};
        if (count_s == {CW{1'b0}}) begin
            head_s = {WIDTH{1'b0}};
        end else if (push_eff_s && (wr_ptr_r == rd_ptr_s)) begin
            head_s = push_data;
        end else begin
            head_s = mem_r[rd_ptr_s];
        end
    end

    // Pointer, count and registered head state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            head_r   <= {WIDTH{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_s;
            rd_ptr_r <= rd_ptr_s;
            count_r  <= count_s;
            head_r   <= head_s;
            valid_r  <= (count_s != {CW{1'b0}});
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push_eff_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    assign count      = count_r;
    assign head_valid = valid_r;
    assign head_data  = head_r;

endmodule

// File: rtl/ifstage_prefetch.sv
// Instruction-fetch front end: fetch PC, single-outstanding memory read FSM,
// and an instruction queue presenting {PC, word} pairs to decode.
module ifstage_prefetch
    import ifstage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    ifstage_prefetch_if.master bus
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    fetch_state_t  state_r, state_s;
    logic [31:0]   fpc_r, fpc_s;
    logic          req_r, req_s;
    logic [31:0]   addr_r, addr_s;
    logic          push_s, pop_s, room_s;
    logic [CW-1:0] count_s;
    logic          head_valid_s;
    logic [63:0]   head_data_s;

    assign room_s = (count_s < DEPTH_C);
    assign pop_s  = head_valid_s && bus.Instr_ready && !bus.Br_valid;

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (!bus.Br_valid && room_s) state_s = S_WAIT;
                else                         state_s = S_IDLE;
            end
            S_WAIT: begin
                if (bus.IMem_ack)      state_s = S_IDLE;
                else if (bus.Br_valid) state_s = S_DROP;
                else                   state_s = S_WAIT;
            end
            S_DROP: begin
                if (bus.IMem_ack) state_s = S_IDLE;
                else              state_s = S_DROP;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, fetch PC and queue push.
    always_comb begin
        req_s  = req_r;
        addr_s = addr_r;
        fpc_s  = fpc_r;
        push_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (!bus.Br_valid && room_s) begin
                    req_s  = 1'b1;
                    addr_s = fpc_r;
                end else begin
                    req_s  = 1'b0;
                end
            end
            S_WAIT: begin
                if (bus.IMem_ack) begin
                    req_s = 1'b0;
                    if (!bus.Br_valid) begin
                        push_s = 1'b1;
                        fpc_s  = fpc_r + PC_INCR;
                    end else begin
                        push_s = 1'b0;
                    end
                end else begin
                    req_s = 1'b1;
                end
            end
            S_DROP: begin
                if (bus.IMem_ack) req_s = 1'b0;
                else              req_s = 1'b1;
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
        // A redirect overrides any increment.
        if (bus.Br_valid) begin
            fpc_s = align_word(bus.Br_target);
        end else begin
            fpc_s = fpc_s;
        end
    end

    // Output and fetch-PC registers.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            req_r  <= 1'b0;
            addr_r <= RESET_PC;
            fpc_r  <= RESET_PC;
        end else begin
            req_r  <= req_s;
            addr_r <= addr_s;
            fpc_r  <= fpc_s;
        end
    end

    ifstage_queue #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (64),
        .CW    (CW)
    ) u_queue (
        .clk        (Clk),
        .rst_n      (Reset),
        .push       (push_s),
        .push_data  ({fpc_r, bus.IMem_rdata}),
        .pop        (pop_s),
        .flush      (bus.Br_valid),
        .count      (count_s),
        .head_valid (head_valid_s),
        .head_data  (head_data_s)
    );

    assign bus.IMem_req    = req_r;
    assign bus.IMem_addr   = addr_r;
    assign bus.Instr_valid = head_valid_s;
    assign bus.Instr       = head_data_s[31:0];
    assign bus.Instr_PC    = head_data_s[63:32];

endmodule
